sync_fifo_prog: RTL and testbench
=================================

Name: sync_fifo_prog

Overview:
Next-generation synchronous FIFO for the moving-average datapath. It provides a register-array store with FWFT or standard read mode and programmable, runtime-adjustable prog_full/prog_empty thresholds. It also exposes an occupancy count and registered overflow/underflow error pulses. It is used as the sample delay line and as rate-decoupling buffers between filter stages. Single clock domain.

Parameters:
DATA_WIDTH, 8, data word width (>=1)
ADDR_WIDTH, 4, address width (>=1); DEPTH = 2**ADDR_WIDTH
RAM_STYLE, "distributed", storage attribute: "distributed" or "block"
FWFT_EN, 1, 1 = first-word fall-through, 0 = standard read with 1-cycle latency

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
din  input  DATA_WIDTH  write data
wr_en  input  1  write request
full  output  1  count == DEPTH
almost_full  output  1  count >= DEPTH-1
prog_full  output  1  count >= prog_full_thresh
overflow  output  1  one-cycle pulse: previous-cycle write rejected
prog_full_thresh  input  ADDR_WIDTH+1  prog_full threshold, 1..DEPTH
dout  output  DATA_WIDTH  read data
rd_en  input  1  read request / pop
valid  output  1  dout holds valid popped/head data
empty  output  1  count == 0
almost_empty  output  1  count <= 1
prog_empty  output  1  count <= prog_empty_thresh
underflow  output  1  one-cycle pulse: previous-cycle read rejected
prog_empty_thresh  input  ADDR_WIDTH+1  prog_empty threshold, 0..DEPTH-1
data_count  output  ADDR_WIDTH+1  current occupancy 0..DEPTH

Behaviour:
- Reset is synchronous: when rst is high at a clk edge, rptr=wptr=0 and overflow=underflow=valid=0.
- Values after reset: empty=1, almost_empty=1, prog_empty=1, full=0, almost_full=0, prog_full=0 (for legal threshold), data_count=0.
- dout is unchanged by reset. Memory contents are not cleared.
- Reset overrides any wr_en/rd_en in the same cycle. Reset mid-operation discards all contents.
- Pointers are ADDR_WIDTH+1 bits. Address = low bits. The MSB distinguishes full from empty. Both pointers wrap naturally modulo 2*DEPTH.
- data_count = wptr - rptr (modulo 2**(ADDR_WIDTH+1)).
- All status flags are combinational from the registered pointers and threshold inputs. No extra latency.
- Write is accepted iff wr_en & ~full. On acceptance, mem[waddr] <= din and wptr increments.
- Write on full is rejected, including when a read occurs in the same cycle. overflow=1 on the next cycle.
- Read is accepted iff rd_en & ~empty and rptr increments.
- Read on empty is rejected, including when a write occurs in the same cycle. underflow=1 on the next cycle.
- A simultaneous accepted read and write leaves data_count unchanged.
- Thresholds are sampled continuously; a threshold change takes effect in the same cycle.
  - prog_full_thresh=0 is illegal and forces prog_full=1.
  - prog_empty_thresh>=DEPTH forces prog_empty=1.
- FWFT_EN=1:
  - dout = mem[raddr] whenever ~empty, and valid = ~empty.
  - rd_en acknowledges (pops) the head word.
  - A word written into an empty FIFO appears on dout the cycle after the write edge.
  - When empty, dout holds the last popped word and valid=0.
- FWFT_EN=0:
  - On an accepted read, dout <= mem[raddr] at the edge, and valid=1 for exactly the following cycle.
  - Otherwise valid=0 and dout holds its value.
  - Read latency is 1 cycle.
- Write-to-read is not forwarded: a word is readable the cycle after it is written.

Decomposition:
- Shared package/header fifo_pkg:
  - DEPTH and pointer-width constant functions (clog2, depth from ADDR_WIDTH).
  - Legal RAM_STYLE string constants.
- Sub-module sync_fifo_ram: simple dual-port register array carrying the ram_style attribute.
  - Ports: synchronous write (we, waddr, wdata); asynchronous read (raddr, rdata).
  - Top-level owns pointers, flags, counters and the output register.

Test Plan:
1. ADDR_WIDTH=2, FWFT_EN=1, reset, then write 0xA1,0xA2,0xA3,0xA4 -> after 1st write empty=0, valid=1, dout=0xA1; after 4th full=1, data_count=4, almost_full asserted at count 3.
2. Full FIFO, wr_en=1 din=0xFF with rd_en=1 -> read accepted, write rejected, overflow=1 next cycle only, data_count=3, popped data 0xA1, 0xFF never appears.
3. Empty FIFO, rd_en=1 with wr_en=1 din=0x55 -> underflow=1 next cycle, data_count=1, dout=0x55 with valid=1 (FWFT).
4. FWFT_EN=0: write 0x10,0x20 then rd_en two cycles -> valid high on the cycle after each accepted read edge, dout=0x10 then 0x20; holds 0x20 with valid=0 afterwards.
5. prog_full_thresh=3, prog_empty_thresh=1, ADDR_WIDTH=2: fill to counts 1..4 -> prog_empty=1 at 0,1 and 0 at 2; prog_full=1 at 3,4. Change prog_full_thresh to 4 at count 3 -> prog_full drops the same cycle.
6. Continuous write+read for 20 cycles through pointer wrap, then assert rst mid-stream with wr_en=1 -> in-order data, count constant before rst; after rst edge empty=1, data_count=0, valid=0, overflow=underflow=0, and the concurrent write is discarded.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam string RAM_STYLE_DIST  = "distributed";
  localparam string RAM_STYLE_BLOCK = "block";

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result = result + 1;
    return result;
  endfunction

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  // Extra MSB distinguishes full from empty when the address bits match.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter string       RAM_STYLE  = RAM_STYLE_DIST
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  // The attribute must be a literal for most tools, hence one branch per style.
  if (RAM_STYLE == RAM_STYLE_BLOCK) begin : g_block
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
  end else begin : g_dist
    (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with FWFT/standard read, programmable thresholds and error pulses.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter string       RAM_STYLE  = RAM_STYLE_DIST,
  parameter bit          FWFT_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic                  prog_full,
  output logic                  overflow,
  input  logic [ADDR_WIDTH:0]   prog_full_thresh,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  rd_en,
  output logic                  valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  prog_empty,
  output logic                  underflow,
  input  logic [ADDR_WIDTH:0]   prog_empty_thresh,
  output logic [ADDR_WIDTH:0]   data_count
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int unsigned PW    = ptr_width(ADDR_WIDTH);

  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  wr_acc;
  logic                  rd_acc;

  assign data_count   = wptr - rptr;
  assign full         = (data_count == PW'(DEPTH));
  assign empty        = (data_count == PW'(0));
  assign almost_full  = (data_count >= PW'(DEPTH - 1));
  assign almost_empty = (data_count <= PW'(1));
  assign prog_full    = (prog_full_thresh == PW'(0)) || (data_count >= prog_full_thresh);
  assign prog_empty   = (prog_empty_thresh >= PW'(DEPTH)) || (data_count <= prog_empty_thresh);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Pointers and registered error pulses; reset wins over any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + PW'(1);
      if (rd_acc) rptr <= rptr + PW'(1);
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  // Popped word; deliberately not reset so dout survives a reset.
  always_ff @(posedge clk) begin
    if (rd_acc && !rst) dout_q <= rdata;
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_STYLE  (RAM_STYLE)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc && !rst),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata (din),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdata (rdata)
  );

  if (FWFT_EN) begin : g_fwft
    assign dout  = empty ? dout_q : rdata;
    assign valid = !empty;
  end else begin : g_std
    logic valid_q;
    always_ff @(posedge clk) begin
      if (rst) valid_q <= 1'b0;
      else     valid_q <= rd_acc;
    end
    assign dout  = dout_q;
    assign valid = valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed plus random checks of an FWFT and a standard-read FIFO against queue models.
module tb_sync_fifo_prog;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] a_din = '0, b_din = '0;
  logic a_wr = 1'b0, a_rd = 1'b0, b_wr = 1'b0, b_rd = 1'b0;
  logic [AW:0] a_pft = 3'd3, a_pet = 3'd1, b_pft = 3'd3, b_pet = 3'd1;
  logic a_full, a_afull, a_pfull, a_ovf, a_valid, a_empty, a_aempty, a_pempty, a_unf;
  logic b_full, b_afull, b_pfull, b_ovf, b_valid, b_empty, b_aempty, b_pempty, b_unf;
  logic [DW-1:0] a_dout, b_dout;
  logic [AW:0] a_cnt, b_cnt;

  sync_fifo_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_STYLE("distributed"), .FWFT_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .din(a_din), .wr_en(a_wr), .full(a_full), .almost_full(a_afull),
    .prog_full(a_pfull), .overflow(a_ovf), .prog_full_thresh(a_pft), .dout(a_dout), .rd_en(a_rd),
    .valid(a_valid), .empty(a_empty), .almost_empty(a_aempty), .prog_empty(a_pempty),
    .underflow(a_unf), .prog_empty_thresh(a_pet), .data_count(a_cnt));

  sync_fifo_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_STYLE("block"), .FWFT_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .din(b_din), .wr_en(b_wr), .full(b_full), .almost_full(b_afull),
    .prog_full(b_pfull), .overflow(b_ovf), .prog_full_thresh(b_pft), .dout(b_dout), .rd_en(b_rd),
    .valid(b_valid), .empty(b_empty), .almost_empty(b_aempty), .prog_empty(b_pempty),
    .underflow(b_unf), .prog_empty_thresh(b_pet), .data_count(b_cnt));

  int n_checks = 0;
  int n_fails  = 0;

  // Reference state: contents as queues, plus the observable side registers.
  logic [DW-1:0] qa[$], qb[$];
  logic [DW-1:0] a_last, b_dexp;
  bit a_known = 0, b_known = 0, b_vld = 0;
  bit ea_ovf = 0, ea_unf = 0, eb_ovf = 0, eb_unf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a();
    int c;
    c = qa.size();
    chk("a_count", 32'(a_cnt), c);
    chk("a_empty", 32'(a_empty), 32'(c == 0));
    chk("a_full", 32'(a_full), 32'(c == DEPTH));
    chk("a_almost_full", 32'(a_afull), 32'(c >= DEPTH - 1));
    chk("a_almost_empty", 32'(a_aempty), 32'(c <= 1));
    chk("a_prog_full", 32'(a_pfull), 32'((a_pft == 0) || (c >= int'(a_pft))));
    chk("a_prog_empty", 32'(a_pempty), 32'((a_pet >= DEPTH) || (c <= int'(a_pet))));
    chk("a_overflow", 32'(a_ovf), 32'(ea_ovf));
    chk("a_underflow", 32'(a_unf), 32'(ea_unf));
    chk("a_valid", 32'(a_valid), 32'(c != 0));
    if (c != 0) chk("a_dout_head", 32'(a_dout), 32'(qa[0]));
    else if (a_known) chk("a_dout_hold", 32'(a_dout), 32'(a_last));
  endtask

  task automatic check_b();
    int c;
    c = qb.size();
    chk("b_count", 32'(b_cnt), c);
    chk("b_empty", 32'(b_empty), 32'(c == 0));
    chk("b_full", 32'(b_full), 32'(c == DEPTH));
    chk("b_almost_full", 32'(b_afull), 32'(c >= DEPTH - 1));
    chk("b_almost_empty", 32'(b_aempty), 32'(c <= 1));
    chk("b_prog_full", 32'(b_pfull), 32'((b_pft == 0) || (c >= int'(b_pft))));
    chk("b_prog_empty", 32'(b_pempty), 32'((b_pet >= DEPTH) || (c <= int'(b_pet))));
    chk("b_overflow", 32'(b_ovf), 32'(eb_ovf));
    chk("b_underflow", 32'(b_unf), 32'(eb_unf));
    chk("b_valid", 32'(b_valid), 32'(b_vld));
    if (b_known) chk("b_dout", 32'(b_dout), 32'(b_dexp));
  endtask

  // Apply one clock edge to the models using the inputs currently driven.
  task automatic model_edge();
    bit f, e;
    if (rst) begin
      qa.delete(); qb.delete();
      ea_ovf = 0; ea_unf = 0; eb_ovf = 0; eb_unf = 0; b_vld = 0;
    end else begin
      f = (qa.size() == DEPTH); e = (qa.size() == 0);
      ea_ovf = a_wr && f; ea_unf = a_rd && e;
      if (a_rd && !e) begin a_last = qa.pop_front(); a_known = 1; end
      if (a_wr && !f) qa.push_back(a_din);
      f = (qb.size() == DEPTH); e = (qb.size() == 0);
      eb_ovf = b_wr && f; eb_unf = b_rd && e;
      b_vld = b_rd && !e;
      if (b_rd && !e) begin b_dexp = qb.pop_front(); b_known = 1; end
      if (b_wr && !f) qb.push_back(b_din);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_a();
    check_b();
  endtask

  task automatic set_a(input bit wr, input logic [DW-1:0] d, input bit rd);
    a_wr = wr; a_din = d; a_rd = rd;
  endtask

  task automatic set_b(input bit wr, input logic [DW-1:0] d, input bit rd);
    b_wr = wr; b_din = d; b_rd = rd;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Fill the FWFT FIFO; head appears the cycle after the first write
    set_a(1, 8'hA1, 0); tick();
    chk("t1_first_dout", 32'(a_dout), 32'h A1);
    chk("t1_first_valid", 32'(a_valid), 32'd1);
    set_a(1, 8'hA2, 0); tick();
    set_a(1, 8'hA3, 0); tick();
    chk("t1_almost_full_at3", 32'(a_afull), 32'd1);
    set_a(1, 8'hA4, 0); tick();
    chk("t1_full", 32'(a_full), 32'd1);
    chk("t1_count4", 32'(a_cnt), 32'd4);

    // Write on full with a concurrent read: read only
    set_a(1, 8'hFF, 1); tick();
    chk("t2_overflow", 32'(a_ovf), 32'd1);
    chk("t2_count3", 32'(a_cnt), 32'd3);
    chk("t2_head", 32'(a_dout), 32'h A2);
    set_a(0, 8'h00, 0); tick();
    chk("t2_overflow_pulse", 32'(a_ovf), 32'd0);

    // Threshold change acts without a clock edge
    a_pft = 3'd4; #1;
    check_a();
    chk("t5_prog_full_drop", 32'(a_pfull), 32'd0);
    a_pft = 3'd3; #1;

    // Drain, then one rejected read
    set_a(0, 8'h00, 1);
    repeat (3) tick();
    chk("t2_no_ff", 32'(a_last), 32'h A4);
    tick();
    chk("t3_underflow_drain", 32'(a_unf), 32'd1);

    // Read on empty with a concurrent write
    set_a(1, 8'h55, 1); tick();
    chk("t3_underflow", 32'(a_unf), 32'd1);
    chk("t3_count1", 32'(a_cnt), 32'd1);
    chk("t3_dout", 32'(a_dout), 32'h55);
    set_a(0, 8'h00, 1); tick();
    set_a(0, 8'h00, 0); tick();
    chk("t3_hold_last", 32'(a_dout), 32'h55);

    // Standard read mode: one-cycle latency and hold
    set_b(1, 8'h10, 0); tick();
    set_b(1, 8'h20, 0); tick();
    set_b(0, 8'h00, 1); tick();
    chk("t4_dout1", 32'(b_dout), 32'h10);
    chk("t4_valid1", 32'(b_valid), 32'd1);
    tick();
    chk("t4_dout2", 32'(b_dout), 32'h20);
    set_b(0, 8'h00, 0); tick();
    chk("t4_hold", 32'(b_dout), 32'h20);
    chk("t4_valid_low", 32'(b_valid), 32'd0);

    // Random traffic including illegal thresholds
    for (int i = 0; i < 300; i++) begin
      set_a(1'($urandom_range(1, 0)), 8'($urandom), 1'($urandom_range(1, 0)));
      set_b(1'($urandom_range(1, 0)), 8'($urandom), 1'($urandom_range(1, 0)));
      if ((i % 16) == 0) begin
        a_pft = 3'($urandom_range(4, 0)); a_pet = 3'($urandom_range(7, 0));
        b_pft = 3'($urandom_range(4, 0)); b_pet = 3'($urandom_range(7, 0));
      end
      tick();
    end
    a_pft = 3'd3; a_pet = 3'd1; b_pft = 3'd3; b_pet = 3'd1;
    set_b(0, 8'h00, 0);

    // Streaming through pointer wrap, then reset mid-stream
    set_a(0, 8'h00, 1);
    repeat (5) tick();
    set_a(1, 8'h01, 0); tick();
    set_a(1, 8'h02, 0); tick();
    for (int i = 0; i < 20; i++) begin
      set_a(1, 8'(8'h03 + i), 1); tick();
      chk("t6_steady_count", 32'(a_cnt), 32'd2);
    end
    rst = 1'b1; set_a(1, 8'hEE, 0); tick();
    chk("t6_rst_empty", 32'(a_empty), 32'd1);
    chk("t6_rst_count", 32'(a_cnt), 32'd0);
    chk("t6_rst_valid", 32'(a_valid), 32'd0);
    rst = 1'b0; set_a(0, 8'h00, 0); tick();
    chk("t6_write_discarded", 32'(a_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
